// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_pkg.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__muxn_pkg
// Shared types and width helpers for the N-channel synchronous mux.
//   muxn_state_e      : two-state sequencer encoding (steady / dead gap)
//   muxn_clog2()      : ceil(log2(n)), used for the select width
//   muxn_cnt_width()  : gap counter width, never narrower than one bit
// ---------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu9t5v0__muxn_pkg;

  typedef enum logic {
    ST_STEADY = 1'b0,
    ST_GAP    = 1'b1
  } muxn_state_e;

  function automatic int muxn_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int muxn_cnt_width(input int gap);
    int w;
    w = muxn_clog2(gap + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// ---------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__muxn_sync
// NCH-channel, WIDTH-bit registered mux with handshaked channel select and a
// break-before-make dead gap of GAP cycles on every channel change, so the
// consumer never sees a mix of old and new channel data.
//
// Ports
//   CLK        in   rising-edge clock
//   RN         in   asynchronous active-low reset
//   I          in   channel data, channel c at I[c*WIDTH +: WIDTH]
//   SEL_REQ    in   requested channel
//   SEL_VLD    in   request valid (held by requester until accepted)
//   SEL_RDY    out  request can be accepted this cycle
//   ERR_CLR    in   synchronous clear of ERR
//   Z          out  registered selected data
//   SEL_CUR    out  channel currently driving Z
//   SWITCHING  out  dead gap in progress
//   ERR        out  sticky out-of-range request flag
//   VDD, VSS   io   supply pins, no functional role
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_STEADY | Z follows I[SEL_CUR]; select requests accepted
// ST_GAP    | Z held at IDLE_VAL while the gap counter runs down
// ---------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__muxn_sync
  import gf180mcu_fd_sc_mcu9t5v0__muxn_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter int              NCH      = 4,
  parameter int              GAP      = 2,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0,
  localparam int             SELW     = muxn_clog2(NCH)
) (
  input  logic                   CLK,
  input  logic                   RN,
  input  logic [NCH*WIDTH-1:0]   I,
  input  logic [SELW-1:0]        SEL_REQ,
  input  logic                   SEL_VLD,
  output logic                   SEL_RDY,
  input  logic                   ERR_CLR,
  output logic [WIDTH-1:0]       Z,
  output logic [SELW-1:0]        SEL_CUR,
  output logic                   SWITCHING,
  output logic                   ERR,
  inout  wire                    VDD,
  inout  wire                    VSS
);

  localparam int              CNTW     = muxn_cnt_width(GAP);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'((GAP > 0) ? (GAP - 1) : 0);

  muxn_state_e      state_q, state_d;
  logic [SELW-1:0]  sel_cur_q, sel_cur_d;
  logic [SELW-1:0]  tgt_q, tgt_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             err_q, err_d;

  logic             accept;
  logic             reject;
  logic [31:0]      req_ext;

  // Supplies are carried for netlist compatibility only.
  wire unused_supply = VDD ^ VSS;

  // Zero-extend so the range test stays meaningful when NCH is a power of two.
  assign req_ext = 32'(SEL_REQ);
  assign accept  = SEL_VLD && (state_q == ST_STEADY);
  assign reject  = accept && (req_ext >= 32'(NCH));

  always_comb begin
    state_d   = state_q;
    sel_cur_d = sel_cur_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    err_d     = err_q;

    case (state_q)
      ST_STEADY: begin
        z_d = I[int'(sel_cur_q)*WIDTH +: WIDTH];
        if (accept && !reject && (SEL_REQ != sel_cur_q)) begin
          if (GAP == 0) begin
            sel_cur_d = SEL_REQ;
          end else begin
            tgt_d   = SEL_REQ;
            cnt_d   = CNT_LOAD;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        z_d = IDLE_VAL;
        if (cnt_q == '0) begin
          sel_cur_d = tgt_q;
          state_d   = ST_STEADY;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_STEADY;
      end
    endcase

    // A rejection on the same edge as a clear leaves the flag set.
    if (ERR_CLR) err_d = 1'b0;
    if (reject)  err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_STEADY;
      sel_cur_q <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      z_q       <= IDLE_VAL;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_cur_q <= sel_cur_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      err_q     <= err_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign SEL_RDY   = (state_q == ST_STEADY);
  assign SWITCHING = (state_q == ST_GAP);
  assign Z         = z_q;
  assign SEL_CUR   = sel_cur_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// ---------------------------------------------------------------------------
// Bench for gf180mcu_fd_sc_mcu9t5v0__muxn_sync. Three builds run side by side:
//   inst 0 : NCH=4, GAP=2
//   inst 1 : NCH=3, GAP=2 (select code 3 is out of range)
//   inst 2 : NCH=4, GAP=0
// The reference tracks, per build, the active channel, the pending target and
// how many dead edges remain before that target takes over.
// ---------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync;

  logic        CLK = 1'b0;
  logic        RN  = 1'b0;
  logic [31:0] din = '0;
  logic [1:0]  req [3];
  logic        vld [3];
  logic        clr [3];
  logic [7:0]  z   [3];
  logic [1:0]  cur [3];
  logic        rdy [3];
  logic        sw  [3];
  logic        err [3];
  wire         vdd = 1'b1;
  wire         vss = 1'b0;

  int checks   = 0;
  int failures = 0;

  localparam int NCHS [3] = '{4, 3, 4};
  localparam int GAPS [3] = '{2, 2, 0};

  int         m_cur  [3];
  int         m_tgt  [3];
  int         m_left [3];
  logic       m_err  [3];
  logic [7:0] m_z    [3];

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(4), .GAP(2), .IDLE_VAL(8'h00)) u_dut0 (
    .CLK(CLK), .RN(RN), .I(din), .SEL_REQ(req[0]), .SEL_VLD(vld[0]), .SEL_RDY(rdy[0]),
    .ERR_CLR(clr[0]), .Z(z[0]), .SEL_CUR(cur[0]), .SWITCHING(sw[0]), .ERR(err[0]),
    .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(3), .GAP(2), .IDLE_VAL(8'h00)) u_dut1 (
    .CLK(CLK), .RN(RN), .I(din[23:0]), .SEL_REQ(req[1]), .SEL_VLD(vld[1]), .SEL_RDY(rdy[1]),
    .ERR_CLR(clr[1]), .Z(z[1]), .SEL_CUR(cur[1]), .SWITCHING(sw[1]), .ERR(err[1]),
    .VDD(vdd), .VSS(vss));

  gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(4), .GAP(0), .IDLE_VAL(8'h00)) u_dut2 (
    .CLK(CLK), .RN(RN), .I(din), .SEL_REQ(req[2]), .SEL_VLD(vld[2]), .SEL_RDY(rdy[2]),
    .ERR_CLR(clr[2]), .Z(z[2]), .SEL_CUR(cur[2]), .SWITCHING(sw[2]), .ERR(err[2]),
    .VDD(vdd), .VSS(vss));

  task automatic chk(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cur[i]  = 0;
      m_tgt[i]  = 0;
      m_left[i] = 0;
      m_err[i]  = 1'b0;
      m_z[i]    = 8'h00;
    end
  endtask

  // One rising edge worth of behaviour, evaluated on the inputs present now.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit rej;
      rej = 1'b0;
      if (m_left[i] > 0) begin
        m_z[i] = 8'h00;
        m_left[i]--;
        if (m_left[i] == 0) m_cur[i] = m_tgt[i];
      end else begin
        m_z[i] = din[m_cur[i]*8 +: 8];
        if (vld[i]) begin
          if (int'(req[i]) >= NCHS[i]) rej = 1'b1;
          else if (int'(req[i]) != m_cur[i]) begin
            if (GAPS[i] == 0) m_cur[i] = int'(req[i]);
            else begin
              m_tgt[i]  = int'(req[i]);
              m_left[i] = GAPS[i];
            end
          end
        end
      end
      if (rej) m_err[i] = 1'b1;
      else if (clr[i]) m_err[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("z",         i, 32'(z[i]),   32'(m_z[i]));
      chk("sel_cur",   i, 32'(cur[i]), 32'(m_cur[i]));
      chk("switching", i, 32'(sw[i]),  32'(m_left[i] > 0));
      chk("sel_rdy",   i, 32'(rdy[i]), 32'(m_left[i] == 0));
      chk("err",       i, 32'(err[i]), 32'(m_err[i]));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  // Called 1 time unit after a rising edge: pulses RN low inside the cycle.
  task automatic do_reset();
    #2 RN = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 RN = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = '0;
      vld[i] = 1'b0;
      clr[i] = 1'b0;
    end
    model_reset();
    @(posedge CLK);
    #1;
    check_all();
    RN = 1'b1;
    @(posedge CLK);
    #1;
    do_reset();

    // I[0]=A5, I[1]=11, I[2]=22, I[3]=3C
    din = 32'h3C2211A5;
    step();
    chk("z_after_reset", 0, 32'(z[0]), 32'h0000_00A5);

    // Edge A: inst0 0->3 with gap, inst1 bad select, inst2 -> 1 without gap
    req[0] = 2'd3; vld[0] = 1'b1;
    req[1] = 2'd3; vld[1] = 1'b1;
    req[2] = 2'd1; vld[2] = 1'b1;
    step();
    chk("gap_accept_z",  0, 32'(z[0]),   32'h0000_00A5);
    chk("gap_accept_sw", 0, 32'(sw[0]),  32'd1);
    chk("oor_err",       1, 32'(err[1]), 32'd1);
    chk("oor_sel_cur",   1, 32'(cur[1]), 32'd0);
    chk("g0_sel_cur_1",  2, 32'(cur[2]), 32'd1);

    // Edge B: busy request ignored; clear collides with another rejection
    req[0] = 2'd1;
    clr[1] = 1'b1;
    req[2] = 2'd2;
    step();
    chk("gap1_z",        0, 32'(z[0]),   32'h0000_0000);
    chk("gap1_rdy",      0, 32'(rdy[0]), 32'd0);
    chk("err_set_wins",  1, 32'(err[1]), 32'd1);
    chk("g0_sel_cur_2",  2, 32'(cur[2]), 32'd2);
    chk("g0_z_lag_1",    2, 32'(z[2]),   32'h0000_0011);

    // Edge C: last gap edge; clear alone
    vld[1] = 1'b0;
    req[2] = 2'd0;
    step();
    chk("gap2_z",        0, 32'(z[0]),   32'h0000_0000);
    chk("gap_end_cur",   0, 32'(cur[0]), 32'd3);
    chk("err_clr",       1, 32'(err[1]), 32'd0);
    chk("g0_sel_cur_0",  2, 32'(cur[2]), 32'd0);
    chk("g0_z_lag_2",    2, 32'(z[2]),   32'h0000_0022);

    vld[0] = 1'b0;
    clr[1] = 1'b0;
    vld[2] = 1'b0;
    step();
    chk("new_ch_z",      0, 32'(z[0]),   32'h0000_003C);
    chk("g0_z_lag_0",    2, 32'(z[2]),   32'h0000_00A5);

    // Same-channel request: no gap, data undisturbed
    req[0] = 2'd3; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    step();
    chk("same_ch_sw",    0, 32'(sw[0]),  32'd0);
    chk("same_ch_z",     0, 32'(z[0]),   32'h0000_003C);

    // Reset in the middle of a gap discards the pending target
    req[0] = 2'd1; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    step();
    do_reset();
    step();
    step();
    step();
    chk("rst_gap_cur",   0, 32'(cur[0]), 32'd0);
    chk("rst_gap_z",     0, 32'(z[0]),   32'h0000_00A5);

    // Randomised traffic against the reference
    for (int n = 0; n < 400; n++) begin
      din = $urandom;
      for (int i = 0; i < 3; i++) begin
        vld[i] = 1'($urandom_range(0, 1));
        req[i] = 2'($urandom_range(0, 3));
        clr[i] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 99) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__muxn_sync.md
# gf180mcu_fd_sc_mcu9t5v0__muxn_sync

Parametrised N-channel, WIDTH-bit registered multiplexer with a handshaked select-change port and a programmable dead-gap (break-before-make) during channel switches. Generalises the 2:1 combinational mux cell to multi-channel buses whose consumers must never see a mix of old and new channel data. It sits in datapath steering and test-mux logic, between free-running sources and a single registered consumer.

## Interface
- WIDTH, 8, bits per channel (≥1)
- NCH, 4, number of input channels (2..16)
- GAP, 2, dead cycles forced on Z per channel change (0..15)
- IDLE_VAL, 0, WIDTH-bit value driven on Z during the gap and out of reset
- SELW (localparam), $clog2(NCH), select width

- CLK  input  1  clock, rising edge
- RN  input  1  reset; asynchronous, active-low
- I  input  NCH*WIDTH  channel data; channel c at I[c*WIDTH +: WIDTH]
- SEL_REQ  input  SELW  requested channel
- SEL_VLD  input  1  select request valid
- SEL_RDY  output  1  block can accept a request
- ERR_CLR  input  1  synchronous clear of ERR
- Z  output  WIDTH  registered selected data
- SEL_CUR  output  SELW  channel currently driving Z
- SWITCHING  output  1  gap in progress
- ERR  output  1  sticky: out-of-range request seen
- VDD, VSS  inout  1  supply pins, no functional role

## Operation
- Reset (RN=0, asynchronous): state STEADY, SEL_CUR=0, Z=IDLE_VAL, SWITCHING=0, ERR=0, gap counter=0.
- FSM, two states:
  - STEADY: SEL_RDY=1; Z<=I[SEL_CUR] every edge.
  - GAP: SEL_RDY=0, SWITCHING=1; Z<=IDLE_VAL every edge; counter decrements.
- Accept = SEL_VLD & SEL_RDY at a rising edge. Requests while SEL_RDY=0 are ignored (not queued); the requester holds SEL_VLD.
- Accept with SEL_REQ==SEL_CUR: no-op, stay STEADY, no gap.
- Accept with SEL_REQ≥NCH: rejected, ERR<=1, selection unchanged, stay STEADY.
- Accept with a valid different channel:
  - GAP>0: latch target, counter<=GAP-1, go to GAP.
  - GAP=0: SEL_CUR<=SEL_REQ on the accept edge, stay STEADY.
- GAP state with counter==0: SEL_CUR<=target, go to STEADY; otherwise decrement.
- ERR_CLR=1 clears ERR at the edge. If a rejection happens on the same edge, set wins.
- Counter width is $clog2(GAP+1), minimum 1; it never wraps.

## Timing
- Data latency: 1 cycle. Z after edge t = I[SEL_CUR] sampled at edge t.
- Switch with GAP=g>0, accepted at edge k:
  - Z=I[old] after edge k.
  - Z=IDLE_VAL after edges k+1 … k+g.
  - SEL_CUR=new and state STEADY after edge k+g.
  - Z=I[new] after edge k+g+1.
  - SWITCHING high for exactly g cycles.
  - SEL_RDY low from after edge k until after edge k+g.
- Switch with GAP=0: SEL_CUR changes at edge k; Z=I[new] from edge k+1. Consecutive back-to-back accepts are legal.
- SEL_RDY and SWITCHING are decoded from state only, with no combinational path from inputs.
- Reset asserted mid-gap: immediate return to reset values; the pending target is discarded.

## Structure
- Package gf180mcu_fd_sc_mcu9t5v0__muxn_pkg holds:
  - the state enum {STEADY, GAP};
  - the clog2 helper for SELW and counter width.
- Single module, no sub-module. The NCH:1 selection is a flat indexed part-select feeding the Z register.

## Test plan
- Reset: RN pulsed low mid-cycle → Z=IDLE_VAL=0, SEL_CUR=0, SEL_RDY=1 asynchronously; with I[0]=8'hA5 after release, Z=8'hA5 one edge later.
- Switch with GAP=2: request 0→3 (I[3]=8'h3C) → Z sequence A5, 00, 00, 3C; SWITCHING high for 2 cycles; SEL_CUR=3 after the second gap edge.
- Busy and same-channel requests: request during the gap → ignored, SEL_RDY=0. Request for the current channel → no gap, Z undisturbed.
- Out-of-range request: NCH=3, SEL_REQ=3 → ERR=1, SEL_CUR unchanged. Simultaneous ERR_CLR plus another bad request → ERR stays 1. ERR_CLR alone → ERR=0.
- GAP=0 build: accepts on consecutive edges 1, 2, 0 → SEL_CUR follows each edge, Z lags by 1 with no IDLE_VAL cycle.
- Reset during the gap: RN low at gap cycle 1 → SEL_CUR=0 and Z=IDLE_VAL after release; the old target is never applied.
